// File: rtl/dmem_pkg.sv
// Shared types for the MEM-stage data-memory access controller.
package dmem_pkg;

  // Access sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dmem_state_e;

  // Exception codes reported on exc_code.
  typedef enum logic [1:0] {
    EXC_NONE     = 2'b00,
    EXC_MISALIGN = 2'b01,
    EXC_TIMEOUT  = 2'b10
  } dmem_exc_e;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 32'd15;
  localparam int unsigned DMEM_CNT_W_DEFAULT   = 32'd8;

  // A word access is legal only on a 4-byte boundary.
  function automatic logic is_word_aligned(input logic [31:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_timeout_cnt.sv
// Clearable, saturating wait counter with a terminal-count flag.
module dmem_timeout_cnt
  import dmem_pkg::*;
#(
  parameter int unsigned CNT_W          = DMEM_CNT_W_DEFAULT,
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic clrn,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);

  localparam logic [CNT_W-1:0] TC_VAL  = CNT_W'(TIMEOUT_CYCLES - 32'd1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(32'd1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear wins, increments stop at the all-ones value.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register with asynchronous reset.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == TC_VAL);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Sequences MEM-stage loads/stores over a req/ack data-memory interface,
// stalling the pipeline and raising misalign/timeout exceptions.
module dmem_access_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT,
  parameter int unsigned CNT_W          = DMEM_CNT_W_DEFAULT
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        mwmem,
  input  logic        mm2reg,
  input  logic [31:0] malu,
  input  logic [31:0] di,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        wb_bubble,
  output logic [31:0] mdo,
  output logic        exc_valid,
  output logic [1:0]  exc_code
);

  dmem_state_e state_q;
  logic        req_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mdo_q;
  logic        timeout_q;

  logic        access_s;
  logic        aligned_s;
  logic        start_s;
  logic        cnt_inc_s;
  logic        tc_s;
  logic        stall_s;
  logic        bubble_s;
  logic        exc_valid_s;
  logic [1:0]  exc_code_s;

  assign access_s  = mwmem | mm2reg;
  assign aligned_s = is_word_aligned(malu);
  assign start_s   = (state_q == IDLE) && access_s && aligned_s;
  // Only count cycles that neither complete nor already hit the limit.
  assign cnt_inc_s = (state_q == WAIT) && !mem_ack && !tc_s;

  dmem_timeout_cnt #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk   (clk),
    .clrn  (clrn),
    .clr_i (start_s),
    .inc_i (cnt_inc_s),
    .tc_o  (tc_s)
  );

  // Pipeline control and exception outputs decoded from the current state.
  always_comb begin
    stall_s     = 1'b0;
    bubble_s    = 1'b0;
    exc_valid_s = 1'b0;
    exc_code_s  = EXC_NONE;
    case (state_q)
      IDLE: begin
        if (access_s) begin
          if (aligned_s) begin
            stall_s  = 1'b1;
            bubble_s = 1'b1;
          end else begin
            bubble_s    = 1'b1;
            exc_valid_s = 1'b1;
            exc_code_s  = EXC_MISALIGN;
          end
        end else begin
          stall_s = 1'b0;
        end
      end
      WAIT: begin
        stall_s  = 1'b1;
        bubble_s = 1'b1;
      end
      DONE: begin
        // Pipeline advances here; a timed-out instruction must not write back.
        bubble_s = timeout_q;
        if (timeout_q) begin
          exc_valid_s = 1'b1;
          exc_code_s  = EXC_TIMEOUT;
        end else begin
          exc_valid_s = 1'b0;
        end
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase
  end

  // Access FSM and its registered memory-side outputs.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
      mdo_q     <= 32'h0000_0000;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          timeout_q <= 1'b0;
          if (start_s) begin
            addr_q  <= malu;
            wdata_q <= di;
            // Store takes priority when both request lines are set.
            we_q    <= mwmem;
            req_q   <= 1'b1;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            if (!we_q) begin
              mdo_q <= mem_rdata;
            end
            req_q     <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= DONE;
          end else if (tc_s) begin
            if (!we_q) begin
              mdo_q <= 32'h0000_0000;
            end
            req_q     <= 1'b0;
            timeout_q <= 1'b1;
            state_q   <= DONE;
          end
        end
        DONE: begin
          // The instruction still presented here has completed; never re-issue.
          timeout_q <= 1'b0;
          state_q   <= IDLE;
        end
        default: begin
          req_q     <= 1'b0;
          timeout_q <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q & req_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mdo       = mdo_q;
  assign stall     = stall_s;
  assign wb_bubble = bubble_s;
  assign exc_valid = exc_valid_s;
  assign exc_code  = exc_code_s;

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
- Sequences every MEM-stage data-memory access against a data memory with variable latency and a req/ack handshake.
- Stalls the upstream pipeline and forces a write-back bubble until the access completes.
- Captures load data for the MEM/WB register.
- Detects misaligned addresses and memory timeouts, and reports each as a one-cycle exception.

Parameters:
- TIMEOUT_CYCLES, 15: number of WAIT cycles without ack before the access is abandoned. Legal range 1..255.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- mwmem  in  1  MEM-stage store request.
- mm2reg  in  1  MEM-stage load request.
- malu  in  32  MEM-stage effective address.
- di  in  32  MEM-stage store data.
- mem_req  out  1  request to data memory (registered).
- mem_we  out  1  write enable, valid while mem_req=1.
- mem_addr  out  32  word address, latched at access start.
- mem_wdata  out  32  store data, latched at access start.
- mem_ack  in  1  memory completion, sampled only in WAIT.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- stall  out  1  freezes the PC and the IF/ID, ID/EX and EX/MEM registers.
- wb_bubble  out  1  forces the MEM/WB register's write-enable to 0 for this cycle.
- mdo  out  32  captured load data, held until the next load completes.
- exc_valid  out  1  one-cycle exception pulse.
- exc_code  out  2  01 = misaligned, 10 = timeout, 00 otherwise.

Behaviour:
- Reset (clrn=0, asynchronous):
  - state=IDLE; counter=0.
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mdo=0.
  - stall=0, wb_bubble=0, exc_valid=0, exc_code=00.
- Reset mid-access: mem_req drops immediately and the in-flight access is abandoned, with no exception.
- An access is active when mwmem|mm2reg=1. If both are set, the access is a store (mem_we=1) and mdo is unchanged.
- IDLE:
  - Access active, malu[1:0]=00:
    - stall=1 and wb_bubble=1, combinationally in the same cycle.
    - At the clock edge: latch mem_addr=malu, mem_wdata=di and mem_we; set mem_req=1; counter=0; go to WAIT.
  - Access active, malu[1:0]!=00:
    - No request and no stall.
    - exc_valid=1, exc_code=01, wb_bubble=1 (combinational); stay in IDLE.
  - No access: all combinational outputs 0.
- WAIT:
  - stall=1, wb_bubble=1, and mem_req stays 1.
  - mem_ack=1: if the access is a load, mdo<=mem_rdata. Then mem_req<=0 and go to DONE.
  - mem_ack=0 and counter==TIMEOUT_CYCLES-1: mem_req<=0, set the timeout flag, go to DONE. mdo<=0 if the access is a load.
  - Otherwise counter<=counter+1.
  - mem_ack and the timeout limit in the same cycle: ack wins and no exception is raised.
- DONE (exactly one cycle):
  - stall=0 so the pipeline advances at this edge. wb_bubble=0, or 1 if the timeout flag is set.
  - Timeout flag set: exc_valid=1, exc_code=10.
  - Next state is IDLE unconditionally. The instruction still presented in DONE is never re-issued.
- Latency: with ack in the first WAIT cycle, a memory instruction occupies MEM for 3 cycles (2 stall cycles).
- The counter saturates and never wraps.
- mem_ack outside WAIT is ignored.
- mem_addr and mem_wdata are stable for the whole time mem_req=1.

Decomposition:
- Shared package dmem_pkg:
  - state encoding IDLE=2'b00, WAIT=2'b01, DONE=2'b10.
  - exception codes EXC_NONE=2'b00, EXC_MISALIGN=2'b01, EXC_TIMEOUT=2'b10.
- One natural sub-module, dmem_timeout_cnt: a clearable, saturating CNT_W-bit counter with a terminal-count output compared against TIMEOUT_CYCLES-1.

Test Plan:
- Load, malu=0x0000_0040, ack in the 1st WAIT cycle with rdata=0xDEAD_BEEF -> stall=1 for 2 cycles, mem_we=0, mdo=0xDEAD_BEEF in DONE, no exception.
- Store, malu=0x0000_0100, di=0x1234_5678, ack after 4 WAIT cycles -> mem_we=1, mem_addr/mem_wdata stable throughout, stall=1 for 5 cycles, mdo unchanged.
- Load, malu=0x0000_0042 -> no mem_req, stall=0, same-cycle exc_valid=1, exc_code=01, wb_bubble=1.
- Load with no ack, TIMEOUT_CYCLES=15 -> mem_req high for 15 cycles then 0; DONE shows exc_code=10 and wb_bubble=1; mdo=0.
- Ack coincides with the 15th WAIT cycle -> data captured, no exception.
- clrn=0 asserted during WAIT -> mem_req=0 and all outputs at reset values immediately. After release, an idle bus keeps the state in IDLE.
